id_ex_operand_stage: RTL

ID/EX pipeline stage that feeds the execute-stage ALU in the 5-stage ARM pipeline.
- Selects each source operand from the register file, the EX/MEM result or the MEM/WB result (data forwarding).
- Registers the operands, ALU control and destination info for one cycle.
- Supports stall (hold) and flush (bubble insert) from the hazard detection and branch units.
- Outputs connect directly to the ALU operand, control and carry inputs.

---
 rtl/id_ex_operand_stage_if.sv | 66 ++++++
 rtl/id_ex_operand_stage.sv | 110 +++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - ID/EX operand stage bus: decode, forwarding, control and EX-side outputs
// PERF_CNT_EN adds the three performance counter outputs.
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 6
);
  logic                     id_valid_i;
  logic [ADDRESS_WIDTH-1:0] id_rs1_addr_i;
  logic [ADDRESS_WIDTH-1:0] id_rs2_addr_i;
  logic [DATA_WIDTH-1:0]    id_rs1_data_i;
  logic [DATA_WIDTH-1:0]    id_rs2_data_i;
  logic [DATA_WIDTH-1:0]    id_imm_i;
  logic                     id_use_imm_i;
  logic [3:0]               id_aluctrl_i;
  logic                     id_cin_i;
  logic [ADDRESS_WIDTH-1:0] id_rd_addr_i;
  logic                     id_wreg_i;
  logic                     exmem_wreg_i;
  logic [ADDRESS_WIDTH-1:0] exmem_rd_addr_i;
  logic [DATA_WIDTH-1:0]    exmem_result_i;
  logic                     memwb_wreg_i;
  logic [ADDRESS_WIDTH-1:0] memwb_rd_addr_i;
  logic [DATA_WIDTH-1:0]    memwb_result_i;
  logic                     stall_i;
  logic                     flush_i;

  logic                     ex_valid_o;
  logic [DATA_WIDTH-1:0]    alu_in1_o;
  logic [DATA_WIDTH-1:0]    alu_in2_o;
  logic [3:0]               aluctrl_o;
  logic                     cin_o;
  logic [ADDRESS_WIDTH-1:0] ex_rd_addr_o;
  logic                     ex_wreg_o;
  logic [DATA_WIDTH-1:0]    ex_store_data_o;
  logic [1:0]               fwd_a_o;
  logic [1:0]               fwd_b_o;
`ifdef PERF_CNT_EN
  logic [31:0]              stall_cnt_o;
  logic [31:0]              flush_cnt_o;
  logic [31:0]              fwd_cnt_o;
`endif

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_use_imm_i, id_aluctrl_i, id_cin_i, id_rd_addr_i, id_wreg_i,
           exmem_wreg_i, exmem_rd_addr_i, exmem_result_i,
           memwb_wreg_i, memwb_rd_addr_i, memwb_result_i, stall_i, flush_i,
    input  ex_valid_o, alu_in1_o, alu_in2_o, aluctrl_o, cin_o, ex_rd_addr_o,
           ex_wreg_o, ex_store_data_o, fwd_a_o, fwd_b_o
`ifdef PERF_CNT_EN
           , stall_cnt_o, flush_cnt_o, fwd_cnt_o
`endif
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_use_imm_i, id_aluctrl_i, id_cin_i, id_rd_addr_i, id_wreg_i,
           exmem_wreg_i, exmem_rd_addr_i, exmem_result_i,
           memwb_wreg_i, memwb_rd_addr_i, memwb_result_i, stall_i, flush_i,
    output ex_valid_o, alu_in1_o, alu_in2_o, aluctrl_o, cin_o, ex_rd_addr_o,
           ex_wreg_o, ex_store_data_o, fwd_a_o, fwd_b_o
`ifdef PERF_CNT_EN
           , stall_cnt_o, flush_cnt_o, fwd_cnt_o
`endif
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with EX/MEM and MEM/WB operand forwarding, stall and flush
// PERF_CNT_EN adds stall, flush and forwarded-load counters.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 6
) (
  input logic                  clock,
  input logic                  reset,
  id_ex_operand_stage_if.slave bus
);
  localparam logic [3:0] ALU_NOP = 4'b1111;

  logic [1:0]            fwd_a, fwd_b;
  logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;
  logic                  bubble, load;

  logic                     valid_q, cin_q, wreg_q;
  logic [DATA_WIDTH-1:0]    in1_q, in2_q, store_q;
  logic [3:0]               aluctrl_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [1:0]               fwd_a_q, fwd_b_q;

  // EX/MEM is checked first so the youngest producer wins.
  always_comb begin
    fwd_a   = 2'b00;
    rs1_fwd = bus.id_rs1_data_i;
    if (bus.exmem_wreg_i && bus.exmem_rd_addr_i == bus.id_rs1_addr_i) begin
      fwd_a   = 2'b10;
      rs1_fwd = bus.exmem_result_i;
    end else if (bus.memwb_wreg_i && bus.memwb_rd_addr_i == bus.id_rs1_addr_i) begin
      fwd_a   = 2'b01;
      rs1_fwd = bus.memwb_result_i;
    end
  end

  always_comb begin
    fwd_b   = 2'b00;
    rs2_fwd = bus.id_rs2_data_i;
    if (bus.exmem_wreg_i && bus.exmem_rd_addr_i == bus.id_rs2_addr_i) begin
      fwd_b   = 2'b10;
      rs2_fwd = bus.exmem_result_i;
    end else if (bus.memwb_wreg_i && bus.memwb_rd_addr_i == bus.id_rs2_addr_i) begin
      fwd_b   = 2'b01;
      rs2_fwd = bus.memwb_result_i;
    end
  end

  assign bubble = bus.flush_i || (!bus.stall_i && !bus.id_valid_i);
  assign load   = !bus.flush_i && !bus.stall_i && bus.id_valid_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset || bubble) begin
      valid_q   <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      store_q   <= '0;
      aluctrl_q <= ALU_NOP;
      cin_q     <= 1'b0;
      rd_q      <= '0;
      wreg_q    <= 1'b0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
    end else if (load) begin
      valid_q   <= 1'b1;
      in1_q     <= rs1_fwd;
      in2_q     <= bus.id_use_imm_i ? bus.id_imm_i : rs2_fwd;
      store_q   <= rs2_fwd;
      aluctrl_q <= bus.id_aluctrl_i;
      cin_q     <= bus.id_cin_i;
      rd_q      <= bus.id_rd_addr_i;
      wreg_q    <= bus.id_wreg_i;
      fwd_a_q   <= fwd_a;
      fwd_b_q   <= fwd_b;
    end
  end

  assign bus.ex_valid_o      = valid_q;
  assign bus.alu_in1_o       = in1_q;
  assign bus.alu_in2_o       = in2_q;
  assign bus.ex_store_data_o = store_q;
  assign bus.aluctrl_o       = aluctrl_q;
  assign bus.cin_o           = cin_q;
  assign bus.ex_rd_addr_o    = rd_q;
  assign bus.ex_wreg_o       = wreg_q;
  assign bus.fwd_a_o         = fwd_a_q;
  assign bus.fwd_b_o         = fwd_b_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, fwd_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (bus.stall_i && !bus.flush_i)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.flush_i)
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (load && (fwd_a != 2'b00 || fwd_b != 2'b00))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
  assign bus.fwd_cnt_o   = fwd_cnt_q;
`endif
endmodule
